// File: rtl/seq_shift_add_mult.sv
// Sequential 32x32 -> 64-bit shift-add multiplier, one multiplier bit per clock.
// Accumulate stage is a 32-bit Brent-Kung adder (bkadder, defined below).
// Optional build macro: SIGNED_MULT_EN selects two's-complement operands and a
// signed 64-bit product; when undefined the multiplier is unsigned only.

module bkadder (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        CIN,
  output logic [31:0] SUM,
  output logic        COUT
);

  logic [31:0] prop;
  logic [31:0] grp_g;
  logic [31:0] grp_p;
  logic [32:0] carry;

  // Brent-Kung prefix tree: up-sweep builds power-of-two spans, down-sweep fills the rest.
  always_comb begin
    prop     = A ^ B;
    grp_g    = A & B;
    grp_p    = prop;
    grp_g[0] = grp_g[0] | (prop[0] & CIN);
    for (int lvl = 0; lvl < 5; lvl++) begin
      for (int i = (2 << lvl) - 1; i < 32; i += (2 << lvl)) begin
        grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i - (1 << lvl)]);
        grp_p[i] = grp_p[i] & grp_p[i - (1 << lvl)];
      end
    end
    for (int lvl = 3; lvl >= 0; lvl--) begin
      for (int i = (3 << lvl) - 1; i < 32; i += (2 << lvl)) begin
        grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i - (1 << lvl)]);
        grp_p[i] = grp_p[i] & grp_p[i - (1 << lvl)];
      end
    end
    // grp_g[i] is the carry out of bit i
    carry = {grp_g, CIN};
    SUM   = prop ^ carry[31:0];
    COUT  = carry[32];
  end

endmodule

module seq_shift_add_mult #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [2*WIDTH-1:0]   PRODUCT,
  output logic                 BUSY
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   add_op;
  logic               add_cin;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic               top;
  logic [WIDTH-1:0]   shift_hi;
  logic [WIDTH-1:0]   shift_lo;
  logic               last_iter;

  assign last_iter = (cnt_q == CNT_LAST);

`ifdef SIGNED_MULT_EN
  logic sub_step;

  // Final multiplier bit carries negative weight, so that step subtracts MCAND.
  always_comb begin
    sub_step = lo_q[0] & last_iter;
    add_op   = '0;
    if (lo_q[0]) begin
      add_op = sub_step ? ~mcand_q : mcand_q;
    end
    add_cin = sub_step;
    // Sign bit of the 33-bit sign-extended sum
    top     = hi_q[WIDTH-1] ^ add_op[WIDTH-1] ^ add_cout;
  end
`else
  // Unsigned accumulate: carry out becomes the new accumulator MSB.
  always_comb begin
    add_op  = lo_q[0] ? mcand_q : '0;
    add_cin = 1'b0;
    top     = add_cout;
  end
`endif

  bkadder u_bkadder (
    .A    (hi_q),
    .B    (add_op),
    .CIN  (add_cin),
    .SUM  (add_sum),
    .COUT (add_cout)
  );

  assign shift_hi = {top, add_sum[WIDTH-1:1]};
  assign shift_lo = {add_sum[0], lo_q[WIDTH-1:1]};

  // Next-state: capture in IDLE, shift-add in ITER, hold result in DONE.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          mcand_d = A;
          lo_d    = B;
          hi_d    = '0;
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        hi_d  = shift_hi;
        lo_d  = shift_lo;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          product_d = {shift_hi, shift_lo};
          state_d   = DONE;
        end
      end
      DONE: begin
        if (OUT_READY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; reset aborts any operation in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Handshake and status outputs decode directly from the state register.
  always_comb begin
    IN_READY  = (state_q == IDLE);
    BUSY      = (state_q == ITER);
    OUT_VALID = (state_q == DONE);
    PRODUCT   = product_q;
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Testbench for seq_shift_add_mult; honours SIGNED_MULT_EN the same way as the RTL.

module tb_seq_shift_add_mult;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [63:0] PRODUCT;
  logic        BUSY;

  int checks = 0;
  int errors = 0;

  seq_shift_add_mult dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .PRODUCT   (PRODUCT),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  // Reference product straight from the arithmetic definition.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
`ifdef SIGNED_MULT_EN
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
`else
    ea = {32'h0, a};
    eb = {32'h0, b};
`endif
    return ea * eb;
  endfunction

  // Issue one operand pair and wait (bounded) for OUT_VALID; returns edges since accept.
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] prod, output int lat);
    int w = 0;
    while (IN_READY !== 1'b1 && w < 100) begin
      @(posedge CLK); #1; w++;
    end
    A = a; B = b; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    A = $urandom; B = $urandom;
    lat = 0;
    while (OUT_VALID !== 1'b1 && lat < 100) begin
      @(posedge CLK); #1; lat++;
    end
    prod = PRODUCT;
  endtask

  task automatic retire();
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    checks++;
    if (IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", IN_READY); end
    checks++;
    if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", OUT_VALID); end
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", BUSY); end
    checks++;
    if (PRODUCT !== 64'h0) begin errors++; $display("FAIL reset_product got %h expected 0", PRODUCT); end
  endtask

  task automatic test_basic();
    int lat = 0;
    int bad = 0;
    A = 32'd3; B = 32'd5; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0; A = $urandom; B = $urandom;
    while (OUT_VALID !== 1'b1 && lat < 100) begin
      if (IN_READY !== 1'b0 || BUSY !== 1'b1) bad++;
      @(posedge CLK); #1; lat++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL basic_busy_ready got %0d bad cycles expected 0", bad); end
    checks++;
    if (lat != 32) begin errors++; $display("FAIL basic_latency got %0d expected 32", lat); end
    checks++;
    if (PRODUCT !== 64'hF) begin errors++; $display("FAIL basic_product got %h expected %h", PRODUCT, 64'hF); end
    checks++;
    if (BUSY !== 1'b0 || IN_READY !== 1'b0) begin
      errors++; $display("FAIL basic_done_flags got busy=%b ready=%b expected 0 0", BUSY, IN_READY);
    end
    retire();
    checks++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
      errors++; $display("FAIL basic_retire got valid=%b ready=%b expected 0 1", OUT_VALID, IN_READY);
    end
  endtask

  task automatic test_corners();
    logic [31:0] ta [4];
    logic [31:0] tb [4];
    logic [63:0] te [4];
    logic [63:0] got;
    int lat;
    ta[0] = 32'hFFFF_FFFF; tb[0] = 32'hFFFF_FFFF;
    ta[1] = 32'h8000_0000; tb[1] = 32'h0000_0002;
    ta[2] = 32'h7FFF_FFFF; tb[2] = 32'h8000_0000;
    ta[3] = 32'h0000_0000; tb[3] = 32'h0000_0000;
`ifdef SIGNED_MULT_EN
    te[0] = 64'h0000_0000_0000_0001;
    te[1] = 64'hFFFF_FFFF_0000_0000;
    te[2] = 64'hC000_0000_8000_0000;
`else
    te[0] = 64'hFFFF_FFFE_0000_0001;
    te[1] = 64'h0000_0001_0000_0000;
    te[2] = 64'h3FFF_FFFF_8000_0000;
`endif
    te[3] = 64'h0;
    for (int i = 0; i < 4; i++) begin
      do_mult(ta[i], tb[i], got, lat);
      checks++;
      if (got !== te[i] || lat != 32) begin
        errors++;
        $display("FAIL corner_%0d got %h lat %0d expected %h lat 32", i, got, lat, te[i]);
      end
      retire();
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] got;
    int lat;
    for (int i = 0; i < 20; i++) begin
      a = $urandom; b = $urandom;
      if (i % 5 == 1) a[31] = 1'b1;
      if (i % 5 == 2) b = 32'h1;
      do_mult(a, b, got, lat);
      checks++;
      if (got !== model(a, b) || lat != 32) begin
        errors++;
        $display("FAIL random_%0d a=%h b=%h got %h lat %0d expected %h lat 32",
                 i, a, b, got, lat, model(a, b));
      end
      retire();
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] got;
    logic [63:0] exp_p;
    int lat;
    exp_p = model(32'h1234_5678, 32'h9ABC_DEF0);
    do_mult(32'h1234_5678, 32'h9ABC_DEF0, got, lat);
`ifndef SIGNED_MULT_EN
    checks++;
    if (got !== 64'h0B00_EA4E_242D_2080) begin
      errors++; $display("FAIL bp_const got %h expected %h", got, 64'h0B00_EA4E_242D_2080);
    end
`endif
    checks++;
    if (got !== exp_p) begin errors++; $display("FAIL bp_product got %h expected %h", got, exp_p); end
    for (int i = 0; i < 10; i++) begin
      IN_VALID = (i % 3 != 2);
      A = $urandom; B = $urandom;
      @(posedge CLK); #1;
      checks++;
      if (OUT_VALID !== 1'b1 || PRODUCT !== exp_p || IN_READY !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d got valid=%b ready=%b prod=%h expected 1 0 %h",
                 i, OUT_VALID, IN_READY, PRODUCT, exp_p);
      end
    end
    IN_VALID = 1'b0;
    retire();
    checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0 || PRODUCT !== exp_p) begin
      errors++;
      $display("FAIL bp_after_retire got ready=%b valid=%b prod=%h expected 1 0 %h",
               IN_READY, OUT_VALID, PRODUCT, exp_p);
    end
  endtask

  task automatic test_abort();
    logic [63:0] got;
    int lat;
    int saw = 0;
    A = 32'd7; B = 32'd9; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    checks++;
    if (IN_READY !== 1'b1 || BUSY !== 1'b0 || OUT_VALID !== 1'b0 || PRODUCT !== 64'h0) begin
      errors++;
      $display("FAIL abort_reset got ready=%b busy=%b valid=%b prod=%h expected 1 0 0 0",
               IN_READY, BUSY, OUT_VALID, PRODUCT);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (OUT_VALID !== 1'b0) saw++;
    end
    checks++;
    if (saw != 0) begin errors++; $display("FAIL abort_no_output got %0d valid cycles expected 0", saw); end
    do_mult(32'd2, 32'd3, got, lat);
    checks++;
    if (got !== 64'd6 || lat != 32) begin
      errors++; $display("FAIL abort_restart got %h lat %0d expected 6 lat 32", got, lat);
    end
    retire();
  endtask

  task automatic test_back_to_back();
    logic [63:0] expq [$];
    logic [63:0] exp_p;
    IN_VALID = 1'b1;
    OUT_READY = 1'b1;
    for (int c = 0; c < 34 * 3 + 34; c++) begin
      A = $urandom; B = $urandom;
      checks++;
      if (IN_READY !== (c % 34 == 0)) begin
        errors++; $display("FAIL b2b_ready_c%0d got %b expected %b", c, IN_READY, (c % 34 == 0));
      end
      if (c % 34 == 0) expq.push_back(model(A, B));
      checks++;
      if (OUT_VALID !== (c % 34 == 33)) begin
        errors++; $display("FAIL b2b_valid_c%0d got %b expected %b", c, OUT_VALID, (c % 34 == 33));
      end
      if (c % 34 == 33 && expq.size() > 0) begin
        exp_p = expq.pop_front();
        checks++;
        if (PRODUCT !== exp_p) begin
          errors++; $display("FAIL b2b_product_c%0d got %h expected %h", c, PRODUCT, exp_p);
        end
      end
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_backpressure();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
